mem_access_unit: RTL

- MEM-stage load/store unit for the rv32i pipeline; it is the consumer of the decoded memory fields (MEM_Read, MEM_Write, funct3) that originate in ID.
- Turns one decoded memory op into a single request/response transaction on the data-memory port.
- Aligns store data and byte enables, formats load data (shift plus sign/zero extend), and stalls the pipeline until the data memory responds.
- Sits between the EX/MEM pipeline register and the data cache; the hazard unit consumes its stall output.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns one decoded rv32i memory op into a single
// request/response transaction on the data-memory port and stalls until it completes.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        fault_o,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;

    logic        req, is_load, f3_ok, aligned, legal;
    logic [3:0]  mask;
    logic [31:0] shifted, formatted;

    // Request decode; a simultaneous read+write is handled as a read.
    always_comb begin
        req     = req_valid & (req_read | req_write);
        is_load = req_read;
        case (req_funct3[1:0])
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        if (is_load) f3_ok = req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else         f3_ok = (req_funct3 < 3'd3);
        aligned = (req_funct3[1:0] == 2'd0)
                | ((req_funct3[1:0] == 2'd1) & ~req_addr[0])
                | ((req_funct3[1:0] == 2'd2) & (req_addr[1:0] == 2'b00));
        legal = f3_ok & aligned;
    end

    // Load formatting uses the byte offset and funct3 captured at issue.
    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    formatted = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    formatted = {24'd0, shifted[7:0]};
            3'd1:    formatted = {{16{shifted[15]}}, shifted[15:0]};
            3'd5:    formatted = {16'd0, shifted[15:0]};
            default: formatted = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        f3_d         = f3_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    if (legal) begin
                        addr_d  = {req_addr[31:2], 2'b00};
                        be_d    = mask << req_addr[1:0];
                        wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                        off_d   = req_addr[1:0];
                        f3_d    = req_funct3;
                        rd_d    = is_load;
                        wr_d    = ~is_load;
                        state_d = BUSY;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // cnt_d is the number of BUSY cycles including this one.
                cnt_d = cnt_q + 32'd1;
                if (dmem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                    if (rd_q) begin
                        load_data_d  = formatted;
                        load_valid_d = 1'b1;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_d == TIMEOUT_CYCLES)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign stall_o          = ((state_q == IDLE) & req & legal) | (state_q == BUSY);
    assign load_data_o      = load_data_q;
    assign load_valid_o     = load_valid_q;
    assign fault_o          = fault_q;
    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = addr_q;
    assign dmem_byte_enable = be_q;
    assign dmem_wdata       = wdata_q;

endmodule
